// File: rtl/boot_load_pkg.sv
// Shared state encoding and width helper for the boot load sequencer.
package boot_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    QUIET,
    RUN,
    DROP,
    ERR
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/boot_load_sequencer_cycle_counter.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
module cycle_counter
  import boot_load_pkg::*;
#(
  parameter int unsigned TERMINAL = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int unsigned W = cnt_width(TERMINAL);
  localparam logic [W-1:0] TERM_VAL = W'(TERMINAL);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over enable; the count holds once it reaches the terminal value.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_terminal) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_terminal = (count_q == TERM_VAL);

endmodule

// File: rtl/boot_load_sequencer.sv
// Hands shared data memory from the SPI loader to the core once a complete,
// in-order image has been written and the SPI bus has gone quiet.
module boot_load_sequencer
  import boot_load_pkg::*;
#(
  parameter int unsigned                ADDRESS_LENGTH = 32,
  parameter int unsigned                LOAD_WORDS     = 68,
  parameter logic [ADDRESS_LENGTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                QUIET_CLKS     = 4,
  parameter int unsigned                RST_HOLD_CLKS  = 2,
  parameter int unsigned                TIMEOUT_CLKS   = 4096
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_spi_mem_en,
  input  logic                              i_spi_mem_wr_en,
  input  logic [ADDRESS_LENGTH-1:0]         i_spi_mem_address,
  input  logic                              i_SPI_CS_n,
  input  logic                              i_reload_req,
  output logic                              o_core_select,
  output logic                              o_core_rst_n,
  output logic                              o_load_done,
  output logic                              o_error,
  output logic [$clog2(LOAD_WORDS+1)-1:0]   o_word_count,
  output logic                              o_spi_blocked
);

  localparam int unsigned CW = $clog2(LOAD_WORDS + 1);

  state_e state_q, state_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic core_select_q, core_select_d;
  logic core_rst_n_q, core_rst_n_d;
  logic load_done_q, load_done_d;
  logic error_q, error_d;
  logic spi_blocked_q, spi_blocked_d;

  logic                      strobe;
  logic [ADDRESS_LENGTH-1:0] expected_addr;
  logic                      addr_ok;
  logic                      last_word;
  logic                      timeout_hit;
  logic                      quiet_done;
  logic                      hold_done;

  assign strobe        = i_spi_mem_en & i_spi_mem_wr_en;
  assign expected_addr = BASE_ADDR + (ADDRESS_LENGTH'(word_count_q) << 2);
  assign addr_ok       = (i_spi_mem_address == expected_addr);
  assign last_word     = (word_count_q == CW'(LOAD_WORDS - 1));

  // Idle-cycle gap since the last accepted write; flags on the cycle before expiry.
  cycle_counter #(
    .TERMINAL (TIMEOUT_CLKS - 1)
  ) u_timeout_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    ((state_q != LOAD) || strobe),
    .i_enable   (1'b1),
    .o_terminal (timeout_hit)
  );

  cycle_counter #(
    .TERMINAL (QUIET_CLKS)
  ) u_quiet_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    ((state_q != QUIET) || !i_SPI_CS_n),
    .i_enable   (1'b1),
    .o_terminal (quiet_done)
  );

  cycle_counter #(
    .TERMINAL (RST_HOLD_CLKS - 1)
  ) u_hold_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (state_q != RUN),
    .i_enable   (1'b1),
    .o_terminal (hold_done)
  );

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    spi_blocked_d = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if (i_reload_req) begin
          state_d      = IDLE;
          word_count_d = '0;
        end else if (strobe) begin
          if (addr_ok) begin
            word_count_d = word_count_q + CW'(1);
            state_d      = last_word ? QUIET : LOAD;
          end else begin
            state_d = ERR;
          end
        end else if ((state_q == LOAD) && timeout_hit) begin
          state_d = ERR;
        end
      end

      QUIET: begin
        if (i_reload_req) begin
          state_d      = IDLE;
          word_count_d = '0;
        end else if (strobe) begin
          state_d = ERR;
        end else if (quiet_done) begin
          state_d = RUN;
        end
      end

      RUN: begin
        spi_blocked_d = strobe;
        if (i_reload_req) begin
          state_d = DROP;
        end
      end

      // Core is already held in reset; select is removed on the way out.
      DROP: begin
        spi_blocked_d = strobe;
        state_d       = IDLE;
        word_count_d  = '0;
      end

      ERR: begin
        if (i_reload_req) begin
          state_d      = IDLE;
          word_count_d = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        word_count_d = '0;
      end
    endcase

    core_select_d = (state_d == RUN) || (state_d == DROP);
    core_rst_n_d  = (state_q == RUN) && (state_d == RUN) && hold_done;
    load_done_d   = core_rst_n_d;
    error_d       = (state_d == ERR);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      word_count_q  <= '0;
      core_select_q <= 1'b0;
      core_rst_n_q  <= 1'b0;
      load_done_q   <= 1'b0;
      error_q       <= 1'b0;
      spi_blocked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      core_select_q <= core_select_d;
      core_rst_n_q  <= core_rst_n_d;
      load_done_q   <= load_done_d;
      error_q       <= error_d;
      spi_blocked_q <= spi_blocked_d;
    end
  end

  assign o_core_select = core_select_q;
  assign o_core_rst_n  = core_rst_n_q;
  assign o_load_done   = load_done_q;
  assign o_error       = error_q;
  assign o_word_count  = word_count_q;
  assign o_spi_blocked = spi_blocked_q;

endmodule
